// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed seven-segment display driver.
// Captures a 32-bit word on cs and scans it out as eight hex digits on
// shared active-low segment and digit-select lines.
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [31:0] i_data,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [31:0]      data_reg;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       dig;
  logic [3:0]       nib;
  logic [2:0]       hi_nib;
  logic             blank;
  logic [7:0]       seg_next;

  // Active-low hex-to-seven-segment decode, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Index of the most significant nonzero nibble (0 when the word is zero).
  always_comb begin
    hi_nib = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (data_reg[4*k +: 4] != 4'h0) hi_nib = 3'(k);
    end
  end

  // Segment pattern for the digit currently addressed by dig.
  always_comb begin
    nib      = data_reg[{dig, 2'b00} +: 4];
    blank    = (BLANK_LZ != 0) && (dig > hi_nib);
    seg_next = blank ? '1 : {1'b1, dec(nib)};
  end

  // Data capture register; reset wins over cs.
  always_ff @(posedge clk) begin
    if (!reset)  data_reg <= '0;
    else if (cs) data_reg <= i_data;
  end

  // Refresh counter and digit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      dig <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      dig <= dig + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered display outputs, built from pre-edge dig and data_reg.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_sel <= '1;
      o_seg <= '1;
    end else begin
      o_sel <= ~(8'b1 << dig);
      o_seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: three instances (plain, leading-
// zero blanking, and one-cycle scan) compared every cycle against a
// behavioural model, plus directed literal checks.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] i_data = '0;
  logic [7:0]  seg_a, sel_a, seg_b, sel_b, seg_c, sel_c;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(4), .CNT_W(16), .BLANK_LZ(0)) dut_a (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .o_seg(seg_a), .o_sel(sel_a));
  seg_scan_display #(.SCAN_DIV(4), .CNT_W(16), .BLANK_LZ(1)) dut_b (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .o_seg(seg_b), .o_sel(sel_b));
  seg_scan_display #(.SCAN_DIV(1), .CNT_W(4), .BLANK_LZ(1)) dut_c (
    .clk(clk), .reset(reset), .cs(cs), .i_data(i_data), .o_seg(seg_c), .o_sel(sel_c));

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Model: after the n-th post-reset edge, digit shown is (n/S)%8 using the
  // word held before that edge.
  function automatic logic [15:0] model_out(input int unsigned n, input logic [31:0] d,
                                            input int unsigned s, input bit blank);
    int unsigned dg;
    int unsigned h;
    logic [7:0] sel;
    logic [7:0] seg;
    dg = (n / s) % 8;
    h = 0;
    for (int k = 0; k < 8; k++)
      if (((d >> (4*k)) & 32'hF) != 0) h = k;
    sel = ~(8'b1 << dg);
    seg = SEG_TAB[(d >> (4*dg)) & 32'hF];
    if (blank && dg > h) seg = 8'hFF;
    return {sel, seg};
  endfunction

  int unsigned m_n = 0;
  logic [31:0] m_data = '0;
  bit          m_valid = 0;
  logic [15:0] exp_a = '1, exp_b = '1, exp_c = '1;

  always @(posedge clk) begin
    if (!reset) begin
      m_n = 0;
      m_data = '0;
      exp_a = '1;
      exp_b = '1;
      exp_c = '1;
      m_valid = 1;
    end else begin
      exp_a = model_out(m_n, m_data, 4, 0);
      exp_b = model_out(m_n, m_data, 4, 1);
      exp_c = model_out(m_n, m_data, 1, 1);
      m_n++;
      if (cs) m_data = i_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sel_a", sel_a, exp_a[15:8]);
      check("model_seg_a", seg_a, exp_a[7:0]);
      check("model_sel_b", sel_b, exp_b[15:8]);
      check("model_seg_b", seg_b, exp_b[7:0]);
      check("model_sel_c", sel_c, exp_c[15:8]);
      check("model_seg_c", seg_c, exp_c[7:0]);
    end
  end

  task automatic wait_sel(input logic [7:0] target, input int unsigned budget);
    int unsigned i;
    i = 0;
    while (sel_a !== target && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (sel_a !== target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_sel: got %h, expected %h within %0d cycles", sel_a, target, budget);
    end
  endtask

  task automatic scan_check_a(input logic [7:0] e [8]);
    for (int k = 0; k < 8; k++) begin
      wait_sel(~(8'b1 << k), 8);
      check("scan_seg_a", seg_a, e[k]);
    end
  endtask

  task automatic scan_check_b(input logic [7:0] e [8]);
    for (int k = 0; k < 8; k++) begin
      wait_sel(~(8'b1 << k), 8);
      check("scan_seg_b", seg_b, e[k]);
    end
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1;
    i_data = d;
    @(negedge clk);
    cs = 1'b0;
    wait_sel(8'h7F, 40);
    wait_sel(8'hFE, 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e_hex [8];
    logic [7:0] e_lz1 [8];
    logic [7:0] e_lz0 [8];
    int unsigned gap;
    logic [7:0] prev;

    e_hex = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
    e_lz1 = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    e_lz0 = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset pulse.
    repeat (3) @(negedge clk);
    check("reset_sel", sel_a, 8'hFF);
    check("reset_seg", seg_a, 8'hFF);
    reset = 1'b1;
    @(negedge clk);
    check("first_sel", sel_a, 8'hFE);
    check("first_seg", seg_a, 8'hC0);
    check("first_seg_b", seg_b, 8'hC0);

    // Capture then disturb i_data with cs low; two scans must be unchanged.
    @(negedge clk);
    cs = 1'b1;
    i_data = 32'h89ABCDEF;
    @(negedge clk);
    cs = 1'b0;
    i_data = 32'h12345678;
    wait_sel(8'h7F, 40);
    scan_check_a(e_hex);
    scan_check_a(e_hex);

    // Wrap: FE slot start to next FE slot start is 8*4 cycles.
    wait_sel(8'h7F, 40);
    wait_sel(8'hFE, 8);
    gap = 0;
    prev = sel_a;
    while (gap < 64) begin
      @(negedge clk);
      gap++;
      if (sel_a == 8'hFE && prev != 8'hFE) break;
      prev = sel_a;
    end
    n_checks++;
    if (gap != 32) begin
      n_fail++;
      $display("FAIL wrap_period: got %0d cycles, expected 32", gap);
    end

    // Leading-zero blanking.
    capture(32'h00000120);
    scan_check_b(e_lz1);
    capture(32'h00000000);
    scan_check_b(e_lz0);

    // Reset during digit 5 with a simultaneous capture attempt.
    capture(32'hDEADBEEF);
    wait_sel(8'hDF, 40);
    @(negedge clk);
    reset = 1'b0;
    cs = 1'b1;
    i_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("rst5_sel", sel_a, 8'hFF);
    check("rst5_seg", seg_a, 8'hFF);
    reset = 1'b1;
    cs = 1'b0;
    @(negedge clk);
    check("rst5_rel_sel", sel_a, 8'hFE);
    check("rst5_rel_seg", seg_a, 8'hC0);
    check("rst5_rel_seg_c", seg_c, 8'hC0);

    // Randomized traffic with occasional resets and back-to-back captures.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) != 0);
      cs = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: i_data = $urandom;
        1: i_data = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
        2: i_data = 32'h1 << (4 * $urandom_range(0, 7));
        default: i_data = '0;
      endcase
    end
    @(negedge clk);
    reset = 1'b1;
    cs = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
